mux8_scan_ctrl: RTL and testbench

Sequencer that drives the 3-bit select of the 8:1 bit multiplexer, scans all eight data channels, and assembles the sampled mux output into an 8-bit word. The captured word is presented on a valid/ready output port. It sits directly around the mux: `sel` feeds the mux select, and the mux's 1-bit output returns on `mux_out`. Used wherever the design must read back all eight mux inputs as one parallel word through the single-bit path.

---
 rtl/mux8_scan_ctrl_if.sv | 33 +++
 rtl/mux8_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_mux8_scan_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux8_scan_ctrl_if.sv
// mux8_scan_ctrl_if
// Bundles the scan controller's handshake and mux-facing signals.
//   start      : request a scan (controller input)
//   abort      : cancel the current scan or drop a pending result (controller input)
//   msb_first  : scan order, latched when a scan is accepted (controller input)
//   mux_out    : single-bit output of the external 8:1 mux (controller input)
//   out_ready  : consumer ready for the assembled word (controller input)
//   sel        : registered mux select (controller output)
//   busy       : high while scanning or holding a result (controller output)
//   word       : assembled 8-bit result (controller output)
//   word_valid : result available (controller output)
// The controller connects through 'slave'; whatever drives it uses 'master'.
interface mux8_scan_ctrl_if;
    logic       start;
    logic       abort;
    logic       msb_first;
    logic       mux_out;
    logic       out_ready;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] word;
    logic       word_valid;

    modport master (
        output start, abort, msb_first, mux_out, out_ready,
        input  sel, busy, word, word_valid
    );

    modport slave (
        input  start, abort, msb_first, mux_out, out_ready,
        output sel, busy, word, word_valid
    );
endinterface

// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl
// Steps the select of an external 8:1 bit mux through all eight channels,
// samples the mux output once per channel and assembles the eight samples
// into a parallel word offered on a valid/ready port.
// Parameter:
//   SETTLE : extra cycles each select value is held before sampling (0..3)
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of mux8_scan_ctrl_if (start/abort/msb_first/mux_out/
//            out_ready in; sel/busy/word/word_valid out)
module mux8_scan_ctrl #(
    parameter int SETTLE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    mux8_scan_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        VALID = 2'd2
    } state_t;

    // Value of the settle counter on the cycle a channel is sampled.
    localparam logic [1:0] SETTLE_LAST = SETTLE[1:0];

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] chanCnt_q, chanCnt_d;
    logic [1:0] settleCnt_q, settleCnt_d;
    logic       dir_q, dir_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] word_q, word_d;
    logic       valid_q, valid_d;
    logic       acceptScan;
    logic [7:0] sampled;

    // State register and datapath registers; everything returns to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 3'd0;
            chanCnt_q   <= 3'd0;
            settleCnt_q <= 2'd0;
            dir_q       <= 1'b0;
            shadow_q    <= 8'h00;
            word_q      <= 8'h00;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            chanCnt_q   <= chanCnt_d;
            settleCnt_q <= settleCnt_d;
            dir_q       <= dir_d;
            shadow_q    <= shadow_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
        end
    end

    // Next-state logic. 'sampled' is the shadow with the current channel's bit
    // already inserted, so the final sample can go straight into word on the
    // completing edge. Scan acceptance is shared between IDLE and the
    // back-to-back path out of VALID, so it is applied once after the case.
    // abort is tested first in each state so it wins over start and the handshake.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        chanCnt_d   = chanCnt_q;
        settleCnt_d = settleCnt_q;
        dir_d       = dir_q;
        shadow_d    = shadow_q;
        word_d      = word_q;
        valid_d     = valid_q;
        acceptScan  = 1'b0;
        sampled     = shadow_q;
        sampled[sel_q] = bus.mux_out;

        case (state_q)
            IDLE: begin
                sel_d = 3'd0;
                if (bus.start) begin
                    acceptScan = 1'b1;
                end
            end

            SCAN: begin
                if (bus.abort) begin
                    state_d     = IDLE;
                    sel_d       = 3'd0;
                    chanCnt_d   = 3'd0;
                    settleCnt_d = 2'd0;
                    shadow_d    = 8'h00;
                end else if (settleCnt_q == SETTLE_LAST) begin
                    shadow_d    = sampled;
                    settleCnt_d = 2'd0;
                    chanCnt_d   = chanCnt_q + 3'd1;
                    sel_d       = dir_q ? (sel_q - 3'd1) : (sel_q + 3'd1);
                    if (chanCnt_q == 3'd7) begin
                        word_d  = sampled;
                        valid_d = 1'b1;
                        state_d = VALID;
                        sel_d   = 3'd0;
                    end
                end else begin
                    settleCnt_d = settleCnt_q + 2'd1;
                end
            end

            VALID: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
                    if (bus.start) begin
                        acceptScan = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = 3'd0;
                valid_d = 1'b0;
            end
        endcase

        if (acceptScan) begin
            state_d     = SCAN;
            dir_d       = bus.msb_first;
            sel_d       = bus.msb_first ? 3'd7 : 3'd0;
            chanCnt_d   = 3'd0;
            settleCnt_d = 2'd0;
            shadow_d    = 8'h00;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.word       = word_q;
    assign bus.word_valid = valid_q;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb_mux8_scan_ctrl
// Drives two controllers (SETTLE=0 and SETTLE=2) from one shared stimulus
// stream, each wired to its own behavioural 8:1 mux over a common data byte,
// and compares both against a cycle-level reference model every cycle.
module tb_mux8_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       msbFirst = 1'b0;
    logic       outReady = 1'b0;
    logic [7:0] dData = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux8_scan_ctrl_if bus0 ();
    mux8_scan_ctrl_if bus1 ();

    assign bus0.start     = start;
    assign bus0.abort     = abort;
    assign bus0.msb_first = msbFirst;
    assign bus0.out_ready = outReady;
    assign bus0.mux_out   = dData[bus0.sel];

    assign bus1.start     = start;
    assign bus1.abort     = abort;
    assign bus1.msb_first = msbFirst;
    assign bus1.out_ready = outReady;
    assign bus1.mux_out   = dData[bus1.sel];

    mux8_scan_ctrl #(.SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    mux8_scan_ctrl #(.SETTLE(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // Reference model: a scan is a run of 8*(SETTLE+1) cycles counted by mPos;
    // the channel is mPos/(SETTLE+1), sampled on the last cycle of each slot.
    bit         mScanning[2] = '{0, 0};
    bit         mValid[2]    = '{0, 0};
    bit         mDesc[2]     = '{0, 0};
    int         mPos[2]      = '{0, 0};
    logic [7:0] mShadow[2]   = '{8'h00, 8'h00};
    logic [7:0] mWord[2]     = '{8'h00, 8'h00};

    function automatic int settleOf(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic int chanToSel(input int k, input int ch);
        return mDesc[k] ? (7 - ch) : ch;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            int per;
            int s;
            per = settleOf(k) + 1;
            if (!rst_n) begin
                mScanning[k] = 0;
                mValid[k]    = 0;
                mDesc[k]     = 0;
                mPos[k]      = 0;
                mShadow[k]   = 8'h00;
                mWord[k]     = 8'h00;
            end else if (mValid[k]) begin
                if (abort) begin
                    mValid[k] = 0;
                end else if (outReady) begin
                    mValid[k] = 0;
                    if (start) begin
                        mScanning[k] = 1;
                        mPos[k]      = 0;
                        mDesc[k]     = msbFirst;
                        mShadow[k]   = 8'h00;
                    end
                end
            end else if (mScanning[k]) begin
                if (abort) begin
                    mScanning[k] = 0;
                end else begin
                    if (mPos[k] % per == per - 1) begin
                        s = chanToSel(k, mPos[k] / per);
                        mShadow[k][s] = dData[s];
                    end
                    mPos[k] = mPos[k] + 1;
                    if (mPos[k] == 8 * per) begin
                        mWord[k]     = mShadow[k];
                        mValid[k]    = 1;
                        mScanning[k] = 0;
                    end
                end
            end else if (start) begin
                mScanning[k] = 1;
                mPos[k]      = 0;
                mDesc[k]     = msbFirst;
                mShadow[k]   = 8'h00;
            end
        end
    end

    function automatic logic [12:0] expected(input int k);
        logic [2:0] s;
        s = mScanning[k] ? 3'(chanToSel(k, mPos[k] / (settleOf(k) + 1))) : 3'd0;
        return {s, (mScanning[k] | mValid[k]), mWord[k], mValid[k]};
    endfunction

    task automatic applyStimulus(input logic st, input logic ab, input logic msb,
                                 input logic rdy, input logic [7:0] d);
        start    = st;
        abort    = ab;
        msbFirst = msb;
        outReady = rdy;
        dData    = d;
    endtask

    task automatic checkOutput();
        logic [12:0] act[2];
        logic [12:0] exp;
        act[0] = {bus0.sel, bus0.busy, bus0.word, bus0.word_valid};
        act[1] = {bus1.sel, bus1.busy, bus1.word, bus1.word_valid};
        for (int k = 0; k < 2; k++) begin
            exp = expected(k);
            vectors++;
            if (act[k] !== exp) begin
                miscompares++;
                $display("[TB] FAIL model_inst%0d t=%0t got sel=%0d busy=%0b word=%02h valid=%0b want sel=%0d busy=%0b word=%02h valid=%0b",
                         k, $time, act[k][12:10], act[k][9], act[k][8:1], act[k][0],
                         exp[12:10], exp[9], exp[8:1], exp[0]);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    typedef struct {
        logic       msb;
        logic [7:0] data;
        logic [7:0] expWord;
    } scanVec_t;

    scanVec_t table_[5];

    initial begin
        bit found;
        int lat0;
        int lat1;

        table_[0] = '{msb: 1'b0, data: 8'hA5, expWord: 8'hA5};
        table_[1] = '{msb: 1'b1, data: 8'h3C, expWord: 8'h3C};
        table_[2] = '{msb: 1'b0, data: 8'h00, expWord: 8'h00};
        table_[3] = '{msb: 1'b1, data: 8'hFF, expWord: 8'hFF};
        table_[4] = '{msb: 1'b1, data: 8'h96, expWord: 8'h96};

        // Reset values before any clock edge is relevant.
        #2;
        check("rst_sel0",   32'(bus0.sel), 0);
        check("rst_busy0",  32'(bus0.busy), 0);
        check("rst_word0",  32'(bus0.word), 0);
        check("rst_valid0", 32'(bus0.word_valid), 0);
        #10 rst_n = 1'b1;
        repeat (3) tick();
        check("idle_no_start_busy0", 32'(bus0.busy), 0);

        // Table-driven full scans, out_ready low so the result is held.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, table_[i].msb, 1'b0, table_[i].data);
            tick();
            applyStimulus(1'b0, 1'b0, ~table_[i].msb, 1'b0, table_[i].data);
            lat0 = -1;
            lat1 = -1;
            for (int c = 1; c <= 30; c++) begin
                if (c == 3) start = 1'b1;
                if (c == 4) start = 1'b0;
                tick();
                if (bus0.word_valid && lat0 < 0) lat0 = c;
                if (bus1.word_valid && lat1 < 0) lat1 = c;
            end
            check("tbl_word_s0",    32'(bus0.word), 32'(table_[i].expWord));
            check("tbl_word_s2",    32'(bus1.word), 32'(table_[i].expWord));
            check("tbl_latency_s0", lat0, 8);
            check("tbl_latency_s2", lat1, 24);
            repeat (5) tick();
            check("tbl_hold_s0", 32'(bus0.word_valid), 1);
            check("tbl_hold_s2", 32'(bus1.word_valid), 1);
            outReady = 1'b1;
            tick();
            check("tbl_drop_s0",   32'(bus0.word_valid), 0);
            check("tbl_drop_s2",   32'(bus1.word_valid), 0);
            check("tbl_retain_s0", 32'(bus0.word), 32'(table_[i].expWord));
            outReady = 1'b0;
        end

        // Back-to-back: start held with out_ready high, data changes between scans.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h0F);
        found = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            tick();
            if (bus0.word_valid) found = 1;
        end
        check("b2b_first_seen", 32'(found), 1);
        check("b2b_first_word", 32'(bus0.word), 32'h0F);
        dData = 8'hF0;
        tick();
        check("b2b_valid_dropped", 32'(bus0.word_valid), 0);
        check("b2b_no_idle_busy",  32'(bus0.busy), 1);
        lat0 = -1;
        for (int c = 1; c <= 20 && lat0 < 0; c++) begin
            tick();
            if (bus0.word_valid) lat0 = c;
        end
        check("b2b_second_latency", lat0, 8);
        check("b2b_second_word", 32'(bus0.word), 32'hF0);
        start = 1'b0;
        repeat (40) tick();

        // Abort at channel 4: word keeps the previous result.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h77);
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort_at_ch4_sel", 32'(bus0.sel), 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy",  32'(bus0.busy), 0);
        check("abort_valid", 32'(bus0.word_valid), 0);
        check("abort_word",  32'(bus0.word), 32'hF0);
        check("abort_sel",   32'(bus0.sel), 0);

        // Start and abort together in VALID: result dropped, no new scan.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        tick();
        start = 1'b0;
        found = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            tick();
            if (bus0.word_valid) found = 1;
        end
        check("abort_valid_seen", 32'(found), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        tick();
        check("abort_in_valid_flag", 32'(bus0.word_valid), 0);
        check("abort_in_valid_busy", 32'(bus0.busy), 0);
        check("abort_in_valid_word", 32'(bus0.word), 32'h11);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        tick();
        check("abort_no_restart", 32'(bus0.busy), 0);

        // Asynchronous reset in the middle of a scan.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hC3);
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sel0",   32'(bus0.sel), 0);
        check("async_rst_busy0",  32'(bus0.busy), 0);
        check("async_rst_word0",  32'(bus0.word), 0);
        check("async_rst_valid0", 32'(bus0.word_valid), 0);
        check("async_rst_busy1",  32'(bus1.busy), 0);
        check("async_rst_word1",  32'(bus1.word), 0);
        #3 rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 32'(bus0.busy), 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            start    = ($urandom_range(0, 3) == 0);
            abort    = ($urandom_range(0, 31) == 0);
            msbFirst = 1'($urandom_range(0, 1));
            outReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) dData = 8'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
